bp_be_cmd_queue_mc: RTL and testbench
=====================================

Name: bp_be_cmd_queue_mc

Overview:
- Parametrised, multi-channel successor to the BE director's single-entry FE command buffer.
- Accepts FE commands from chan_p BE producers (director redirect, exception/trap unit, fence/TLB-flush sequencer) and arbitrates them into one els_p-deep FIFO.
- Presents commands in order to the FE command interface.
- Provides full_n/full_r/empty status so the detector and calculator can stall issue before the queue overflows.

Parameters:
- els_p, 4, queue depth in entries; any integer >= 2 (non-power-of-2 legal).
- width_p, 64, command width in bits (set to fe_cmd_width_lp at instantiation).
- chan_p, 2, number of producer channels; >= 1. Channel 0 has highest priority.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- cmd_i  in  chan_p*width_p  producer commands; channel k occupies bits [k*width_p +: width_p].
- cmd_v_i  in  chan_p  per-channel valid.
- cmd_yumi_o  out  chan_p  per-channel accept; one-hot or zero.
- flush_i  in  1  discard all queued entries.
- fe_cmd_o  out  width_p  head command.
- fe_cmd_v_o  out  1  head valid.
- fe_cmd_yumi_i  in  1  FE consumes head.
- full_n_o  out  1  queue will be full next cycle (combinational).
- full_r_o  out  1  queue is full this cycle (registered).
- empty_o  out  1  queue holds zero entries.
- count_o  out  $clog2(els_p+1)  current occupancy.

Behaviour:
- One clock, clk_i. Reset is asynchronous, active-low on reset_n_i.
- While reset_n_i = 0, outputs are forced to: fe_cmd_v_o=0, cmd_yumi_o=0, full_n_o=0, full_r_o=0, empty_o=1, count_o=0.
- Reset assertion mid-operation clears pointers and count immediately. Data RAM contents are don't-care.
- Storage: els_p x width_p register array with read and write pointers.
  - Each pointer increments modulo els_p using an explicit compare against els_p-1, not bit truncation.
  - count_r is held separately.
- Arbitration: fixed priority, lowest index wins. At most one enqueue per cycle.
  - Enqueue condition: any cmd_v_i set, full_r_o=0, flush_i=0.
  - cmd_yumi_o[k]=1 only for the winner. It depends only on cmd_v_i, full_r_o and flush_i; there is no path from fe_cmd_yumi_i.
- Losing channels hold their valid and data. They are not re-prioritised; starvation of higher indices is permitted by design.
- Dequeue:
  - fe_cmd_v_o = ~empty_o.
  - fe_cmd_o = entry at the read pointer.
  - fe_cmd_yumi_i with fe_cmd_v_o=0 is a protocol violation: ignored, and flagged by a simulation-only assertion.
- Latency: an entry written in cycle N is visible on fe_cmd_o in cycle N+1 at the earliest.
- count_n = count_r + enq - deq.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Status outputs:
  - full_n_o = (count_n == els_p), combinational.
  - full_r_o = (count_r == els_p).
  - empty_o = (count_r == 0).
  - count_o = count_r.
- Full: enqueue is blocked even if fe_cmd_yumi_i=1 in the same cycle. The slot frees the following cycle.
- flush_i has priority over everything:
  - Next cycle: count=0, pointers=0.
  - In the flush cycle, all cmd_yumi_o=0.
  - fe_cmd_v_o still reflects the current head. An fe_cmd_yumi_i in the flush cycle is legal and absorbed.
  - full_n_o=0 during flush.

Optional Feature:
- Macro: BP_BE_CMD_QUEUE_BYPASS_EN.
- Defined:
  - When count_r==0 and a winning enqueue is present, fe_cmd_v_o=1 in the same cycle, with fe_cmd_o = winner's data.
  - If fe_cmd_yumi_i=1 that cycle, the entry is not written and count stays 0. Otherwise it is written normally.
  - Flush suppresses bypass.
- Undefined: no combinational cmd_i->fe_cmd_o path. Minimum enqueue-to-visible latency is 1 cycle.

Test Plan:
- Reset: pulse reset_n_i low asynchronously mid-cycle with count=3 -> outputs go to reset values immediately (fe_cmd_v_o=0, empty_o=1, count_o=0) and hold after release.
- Fill/drain (els_p=4, chan_p=2, width_p=8):
  - Channel 0 pushes 0x11,0x22,0x33,0x44 on consecutive cycles with no yumi.
  - Required: count_o reads 1,2,3,4; full_n_o=1 in the 4th push cycle; full_r_o=1 the next cycle.
  - A 5th push of 0x55 sees cmd_yumi_o=00.
  - Drain order is 0x11..0x44, then empty_o=1.
- Arbitration: ch0=0xA0 and ch1=0xB0 valid in the same cycle -> cmd_yumi_o=01; ch1 accepted the next cycle (cmd_yumi_o=10); FE sees 0xA0 then 0xB0.
- Simultaneous push/pop: at count=2, push 0xC3 with fe_cmd_yumi_i=1 -> count stays 2; head advances; 0xC3 emerges after the two older entries.
- Wrap (els_p=3): 10 interleaved push/pop pairs of 0x01..0x0A -> output sequence identical; pointers wrap at 3 without corruption.
- Flush: at count=3 with ch0 valid (0xEE) and flush_i=1 -> cmd_yumi_o=00; next cycle count_o=0 and empty_o=1; 0xEE accepted the following cycle. With BP_BE_CMD_QUEUE_BYPASS_EN, that push plus fe_cmd_yumi_i=1 leaves count_o=0.

Source files
------------

// File: rtl/bp_be_cmd_queue_mc.sv
// -----------------------------------------------------------------------------
// bp_be_cmd_queue_mc
//
// Multi-channel FE command queue for the BE. Up to chan_p BE producers
// (director redirect, exception/trap unit, fence/TLB-flush sequencer) offer
// commands. A fixed-priority arbiter (channel 0 highest) accepts at most one
// per cycle into an els_p-deep FIFO. The FIFO presents commands in order to
// the FE command interface.
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   cmd_i          producer commands, channel k at [k*width_p +: width_p]
//   cmd_v_i        per-channel valid
//   cmd_yumi_o     per-channel accept (one-hot or zero)
//   flush_i        discard all queued entries
//   fe_cmd_o       head command
//   fe_cmd_v_o     head valid
//   fe_cmd_yumi_i  FE consumes head
//   full_n_o       queue will be full next cycle (combinational)
//   full_r_o       queue is full this cycle
//   empty_o        queue holds zero entries
//   count_o        current occupancy
//
// Optional feature, macro BP_BE_CMD_QUEUE_BYPASS_EN:
//   When the queue is empty, the winning command is presented to the FE in
//   the same cycle. If the FE consumes it, the command is never written.
//   When the macro is undefined, there is no cmd_i -> fe_cmd_o path.
// -----------------------------------------------------------------------------
module bp_be_cmd_queue_mc #(
   parameter int els_p   = 4,
   parameter int width_p = 64,
   parameter int chan_p  = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [chan_p*width_p-1:0]    cmd_i,
   input  logic [chan_p-1:0]            cmd_v_i,
   output logic [chan_p-1:0]            cmd_yumi_o,
   input  logic                         flush_i,
   output logic [width_p-1:0]           fe_cmd_o,
   output logic                         fe_cmd_v_o,
   input  logic                         fe_cmd_yumi_i,
   output logic                         full_n_o,
   output logic                         full_r_o,
   output logic                         empty_o,
   output logic [$clog2(els_p+1)-1:0]   count_o
);

   localparam int cnt_w_lp = $clog2(els_p+1);
   localparam int ptr_w_lp = $clog2(els_p);
   localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p-1);
   localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

   // Pointer advance with an explicit wrap compare so non-power-of-2 depths work.
   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      logic [ptr_w_lp-1:0] r;
      if (p == ptr_last_lp) begin
         r = '0;
      end else begin
         r = p + ptr_w_lp'(1);
      end
      return r;
   endfunction

   logic [width_p-1:0]   mem_q [els_p];
   logic [ptr_w_lp-1:0]  wptr_q, wptr_d;
   logic [ptr_w_lp-1:0]  rptr_q, rptr_d;
   logic [cnt_w_lp-1:0]  count_q, count_d;

   logic [chan_p-1:0]    grant_s;
   logic [width_p-1:0]   win_data_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 enq_ok_s;
   logic                 deq_s;
   logic                 byp_take_s;
   logic                 wr_s;

   // Fixed-priority arbiter: lowest valid index wins. Data is and-or muxed.
   always_comb begin
      logic taken;
      taken      = 1'b0;
      grant_s    = '0;
      win_data_s = '0;
      for (int k = 0; k < chan_p; k++) begin
         grant_s[k] = cmd_v_i[k] & ~taken;
         taken      = taken | cmd_v_i[k];
         win_data_s = win_data_s | ({width_p{grant_s[k]}} & cmd_i[k*width_p +: width_p]);
      end
   end

   assign full_s  = (count_q == cnt_full_lp);
   assign empty_s = (count_q == '0);

   // Accept depends only on valids, the registered full flag and flush.
   // Gating with reset_n_i forces zero accepts while reset is held.
   assign enq_ok_s   = reset_n_i & ~flush_i & ~full_s & (|cmd_v_i);
   assign cmd_yumi_o = {chan_p{enq_ok_s}} & grant_s;

   // Only a real head can be consumed. A stray yumi on an empty queue is ignored.
   assign deq_s = fe_cmd_yumi_i & ~empty_s;

`ifdef BP_BE_CMD_QUEUE_BYPASS_EN
   logic byp_s;
   assign byp_s      = empty_s & enq_ok_s;
   assign byp_take_s = byp_s & fe_cmd_yumi_i;
   assign fe_cmd_v_o = reset_n_i & (~empty_s | byp_s);
   assign fe_cmd_o   = empty_s ? win_data_s : mem_q[rptr_q];
`else
   assign byp_take_s = 1'b0;
   assign fe_cmd_v_o = reset_n_i & ~empty_s;
   assign fe_cmd_o   = mem_q[rptr_q];
`endif

   // A bypassed command that the FE takes immediately is never stored.
   assign wr_s = enq_ok_s & ~byp_take_s;

   // Next-state for pointers and occupancy. Flush overrides every other update.
   always_comb begin
      if (flush_i) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         count_d = count_q + cnt_w_lp'(wr_s) - cnt_w_lp'(deq_s);
         wptr_d  = wr_s  ? ptr_inc(wptr_q) : wptr_q;
         rptr_d  = deq_s ? ptr_inc(rptr_q) : rptr_q;
      end
   end

   // Pointer and occupancy registers, cleared immediately on reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Command storage. Contents are don't-care after reset, so there is no reset.
   always_ff @(posedge clk_i) begin
      if (wr_s) begin
         mem_q[wptr_q] <= win_data_s;
      end
   end

   // Status outputs. While reset is held, count_q is already zero, so these show reset values.
   assign full_n_o = reset_n_i & ~flush_i & (count_d == cnt_full_lp);
   assign full_r_o = full_s;
   assign empty_o  = empty_s;
   assign count_o  = count_q;

`ifndef SYNTHESIS
   bp_be_cmd_queue_mc_chk u_chk (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .fe_cmd_v_i    (fe_cmd_v_o),
      .fe_cmd_yumi_i (fe_cmd_yumi_i)
   );
`endif

endmodule

`ifndef SYNTHESIS
// Protocol checker. The FE must not consume when no head is valid.
module bp_be_cmd_queue_mc_chk (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic fe_cmd_v_i,
   input  logic fe_cmd_yumi_i
);
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      fe_cmd_yumi_i |-> fe_cmd_v_i)
      else $error("fe_cmd_yumi_i asserted while fe_cmd_v_o is low");
endmodule
`endif

// File: tb/tb_bp_be_cmd_queue_mc.sv
`timescale 1ns/1ps
module tb_bp_be_cmd_queue_mc;

   localparam int ELS = 4;
   localparam int W   = 8;
   localparam int CH  = 2;
`ifdef BP_BE_CMD_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   // DUT A: els_p=4
   logic [CH*W-1:0] cmd = '0;
   logic [CH-1:0]   v = '0, yumo;
   logic            flush = 1'b0, fe_yumi = 1'b0;
   logic            fe_v, full_n, full_r, empty;
   logic [W-1:0]    fe;
   logic [2:0]      cnt;

   // DUT B: els_p=3, wrap test
   logic [CH*W-1:0] b_cmd = '0;
   logic [CH-1:0]   b_v = '0, b_yumo;
   logic            b_yumi = 1'b0;
   logic            b_fe_v, b_full_n, b_full_r, b_empty;
   logic [W-1:0]    b_fe;
   logic [1:0]      b_cnt;

   bp_be_cmd_queue_mc #(.els_p(ELS), .width_p(W), .chan_p(CH)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .cmd_i(cmd), .cmd_v_i(v), .cmd_yumi_o(yumo),
      .flush_i(flush), .fe_cmd_o(fe), .fe_cmd_v_o(fe_v), .fe_cmd_yumi_i(fe_yumi),
      .full_n_o(full_n), .full_r_o(full_r), .empty_o(empty), .count_o(cnt));

   bp_be_cmd_queue_mc #(.els_p(3), .width_p(W), .chan_p(CH)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .cmd_i(b_cmd), .cmd_v_i(b_v), .cmd_yumi_o(b_yumo),
      .flush_i(1'b0), .fe_cmd_o(b_fe), .fe_cmd_v_o(b_fe_v), .fe_cmd_yumi_i(b_yumi),
      .full_n_o(b_full_n), .full_r_o(b_full_r), .empty_o(b_empty), .count_o(b_cnt));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: a plain queue ----------------
   logic [W-1:0]  mq[$];
   logic [CH-1:0] m_yumi;
   logic          m_fe_v, m_full_n, m_full_r, m_empty, m_enq, m_deq, m_byp_take;
   logic [W-1:0]  m_fe, m_wd;
   int            m_count;

   task automatic model_eval();
      int win;
      int nxt;
      win = -1;
      for (int k = CH-1; k >= 0; k--) if (v[k]) win = k;
      m_full_r = (mq.size() == ELS);
      m_enq    = (win >= 0) && !flush && !m_full_r;
      m_yumi   = '0;
      m_wd     = '0;
      if (m_enq) begin
         m_yumi[win] = 1'b1;
         m_wd        = cmd[win*W +: W];
      end
      m_fe_v     = (mq.size() != 0) || (BYP && m_enq);
      m_fe       = (mq.size() != 0) ? mq[0] : m_wd;
      m_deq      = fe_yumi && (mq.size() != 0);
      m_byp_take = BYP && m_enq && (mq.size() == 0) && fe_yumi;
      nxt        = mq.size() + ((m_enq && !m_byp_take) ? 1 : 0) - (m_deq ? 1 : 0);
      m_full_n   = !flush && (nxt == ELS);
      m_empty    = (mq.size() == 0);
      m_count    = mq.size();
   endtask

   task automatic model_commit();
      if (flush) mq.delete();
      else begin
         if (m_deq) void'(mq.pop_front());
         if (m_enq && !m_byp_take) mq.push_back(m_wd);
      end
   endtask

   task automatic compare_model();
      chk("m_yumi",   32'(yumo),   32'(m_yumi));
      chk("m_fe_v",   32'(fe_v),   32'(m_fe_v));
      if (m_fe_v) chk("m_fe", 32'(fe), 32'(m_fe));
      chk("m_full_n", 32'(full_n), 32'(m_full_n));
      chk("m_full_r", 32'(full_r), 32'(m_full_r));
      chk("m_empty",  32'(empty),  32'(m_empty));
      chk("m_count",  32'(cnt),    32'(m_count));
   endtask

   // First half of a cycle: settle at negedge, evaluate model, optionally compare.
   task automatic half(input bit use_model);
      @(negedge clk);
      model_eval();
      if (use_model) compare_model();
   endtask

   // Second half: commit model, step through the active edge.
   task automatic fin();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [W-1:0] d);
      v = 2'b01; cmd = {8'h00, d}; fe_yumi = 1'b0; flush = 1'b0;
      half(1'b1); fin();
      v = 2'b00;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [CH-1:0] v;
      logic [W-1:0]  d0, d1;
      logic          yumi;
      logic [CH-1:0] e_yumi;
      logic          e_v;
      logic [W-1:0]  e_fe;
      logic [2:0]    e_cnt;
      logic          e_full_n, e_full_r, e_empty;
   } vec_t;
   vec_t tbl[16];

   initial begin
      // fill 0x11..0x44, blocked 5th push while popping, drain
      tbl[0]  = '{2'b01, 8'h11, 8'h00, 1'b0, 2'b01, BYP,  8'h11, 3'd0, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{2'b01, 8'h22, 8'h00, 1'b0, 2'b01, 1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{2'b01, 8'h33, 8'h00, 1'b0, 2'b01, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{2'b01, 8'h44, 8'h00, 1'b0, 2'b01, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{2'b01, 8'h55, 8'h00, 1'b1, 2'b00, 1'b1, 8'h11, 3'd4, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h22, 3'd3, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h44, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1};
      // arbitration: both valid, ch0 first, ch1 next
      tbl[9]  = '{2'b11, 8'hA0, 8'hB0, 1'b0, 2'b01, BYP,  8'hA0, 3'd0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{2'b10, 8'hA0, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hA0, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA0, 3'd2, 1'b0, 1'b0, 1'b0};
      // simultaneous push/pop at count 2
      tbl[12] = '{2'b01, 8'hC3, 8'h00, 1'b1, 2'b01, 1'b1, 8'hA0, 3'd2, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hB0, 3'd2, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hC3, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1};

      // ---- reset state ----
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fe_v",   32'(fe_v),   32'd0);
      chk("rst_empty",  32'(empty),  32'd1);
      chk("rst_count",  32'(cnt),    32'd0);
      chk("rst_full_r", 32'(full_r), 32'd0);
      chk("rst_full_n", 32'(full_n), 32'd0);
      chk("rst_b_empty", 32'(b_empty), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- table ----
      for (int i = 0; i < 16; i++) begin
         v = tbl[i].v; cmd = {tbl[i].d1, tbl[i].d0}; fe_yumi = tbl[i].yumi; flush = 1'b0;
         half(1'b0);
         chk($sformatf("row%0d_yumi", i),   32'(yumo),   32'(tbl[i].e_yumi));
         chk($sformatf("row%0d_fe_v", i),   32'(fe_v),   32'(tbl[i].e_v));
         if (tbl[i].e_v) chk($sformatf("row%0d_fe", i), 32'(fe), 32'(tbl[i].e_fe));
         chk($sformatf("row%0d_count", i),  32'(cnt),    32'(tbl[i].e_cnt));
         chk($sformatf("row%0d_full_n", i), 32'(full_n), 32'(tbl[i].e_full_n));
         chk($sformatf("row%0d_full_r", i), 32'(full_r), 32'(tbl[i].e_full_r));
         chk($sformatf("row%0d_empty", i),  32'(empty),  32'(tbl[i].e_empty));
         fin();
      end
      v = '0; fe_yumi = 1'b0;

      // ---- flush at count 3 with ch0 valid and an FE consume in the same cycle ----
      push0(8'h61); push0(8'h62); push0(8'h63);
      v = 2'b01; cmd = {8'h00, 8'hEE}; flush = 1'b1; fe_yumi = 1'b1;
      half(1'b1);
      chk("flush_yumi",   32'(yumo),   32'd0);
      chk("flush_full_n", 32'(full_n), 32'd0);
      chk("flush_count",  32'(cnt),    32'd3);
      chk("flush_fe",     32'(fe),     32'h61);
      fin();
      flush = 1'b0; fe_yumi = 1'b0;
      half(1'b1);
      chk("postflush_count", 32'(cnt),  32'd0);
      chk("postflush_empty", 32'(empty), 32'd1);
      chk("postflush_yumi",  32'(yumo), 32'd1);
      fin();
      v = '0;
      half(1'b1);
      chk("ee_count", 32'(cnt), 32'd1);
      chk("ee_fe",    32'(fe),  32'hEE);
      fin();
      fe_yumi = 1'b1; half(1'b1); fin(); fe_yumi = 1'b0;
`ifdef BP_BE_CMD_QUEUE_BYPASS_EN
      v = 2'b01; cmd = {8'h00, 8'h5A}; fe_yumi = 1'b1;
      half(1'b1);
      chk("byp_fe_v", 32'(fe_v), 32'd1);
      chk("byp_fe",   32'(fe),   32'h5A);
      chk("byp_yumi", 32'(yumo), 32'd1);
      fin();
      v = '0; fe_yumi = 1'b0;
      half(1'b1);
      chk("byp_count", 32'(cnt), 32'd0);
      fin();
`endif

      // ---- asynchronous reset mid-cycle at count 3 ----
      push0(8'h71); push0(8'h72); push0(8'h73);
      chk("prerst_count", 32'(cnt), 32'd3);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_fe_v",  32'(fe_v),  32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_count", 32'(cnt),   32'd0);
      v = 2'b01; cmd = {8'h00, 8'h99};
      #1;
      chk("arst_yumi",  32'(yumo),  32'd0);
      @(posedge clk); #2;
      chk("arst_hold_count", 32'(cnt), 32'd0);
      v = '0;
      rst_n = 1'b1;
      mq.delete();
      half(1'b1);
      chk("arst_rel_empty", 32'(empty), 32'd1);
      fin();

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 400; i++) begin
         v       = CH'($urandom_range(0, 3));
         cmd     = (CH*W)'($urandom);
         flush   = ($urandom_range(0, 15) == 0);
         fe_yumi = 1'b0;
         model_eval();
         fe_yumi = m_fe_v && ($urandom_range(0, 1) == 1);
         half(1'b1);
         fin();
      end
      v = '0; flush = 1'b0; fe_yumi = 1'b0;

      // ---- wrap on a depth-3 queue: 0x01..0x0A in order, count held at 2 ----
      b_v = 2'b01;
      b_cmd = {8'h00, 8'h01}; @(posedge clk); #1;
      b_cmd = {8'h00, 8'h02}; @(posedge clk); #1;
      for (int k = 3; k <= 10; k++) begin
         b_cmd = {8'h00, 8'(k)}; b_yumi = 1'b1;
         @(negedge clk);
         chk($sformatf("wrap_fe%0d", k-2), 32'(b_fe),   32'(k-2));
         chk("wrap_count",                 32'(b_cnt),  32'd2);
         chk("wrap_yumi",                  32'(b_yumo), 32'd1);
         @(posedge clk); #1;
      end
      b_v = '0;
      for (int k = 9; k <= 10; k++) begin
         b_yumi = 1'b1;
         @(negedge clk);
         chk($sformatf("wrap_fe%0d", k), 32'(b_fe), 32'(k));
         @(posedge clk); #1;
      end
      b_yumi = 1'b0;
      @(negedge clk);
      chk("wrap_empty", 32'(b_empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
